// File: rtl/ovc_credit_status_tracker_if.sv
// Bundle carrying allocator/crossbar/credit events into the OVC tracker and its
// per-OVC status vectors back out to allocator request masking.
interface ovc_credit_status_tracker_if #(
  parameter int V = 4,
  parameter int P = 5,
  parameter int B = 4
);
  localparam int PV = P * V;
  localparam int CW = $clog2(B + 1);

  logic [PV-1:0]    ovc_alloc_all;
  logic [PV-1:0]    flit_sent_all;
  logic [PV-1:0]    tail_sent_all;
  logic [PV-1:0]    credit_in_all;
  logic [PV-1:0]    ovc_avalable_all;
  logic [PV-1:0]    ovc_not_full_all;
  logic [PV*CW-1:0] credit_cnt_all;
  logic [PV-1:0]    err_all;

  modport master (
    output ovc_alloc_all, flit_sent_all, tail_sent_all, credit_in_all,
    input  ovc_avalable_all, ovc_not_full_all, credit_cnt_all, err_all
  );

  modport slave (
    input  ovc_alloc_all, flit_sent_all, tail_sent_all, credit_in_all,
    output ovc_avalable_all, ovc_not_full_all, credit_cnt_all, err_all
  );
endinterface

// File: rtl/ovc_credit_status_tracker.sv
// Per-OVC FREE/BUSY/DRAIN state and saturating credit counter for all P x V
// output VCs; index i = p*V + v. Errors are sticky until reset.
module ovc_credit_status_tracker #(
  parameter int V         = 4,
  parameter int P         = 5,
  parameter int B         = 4,
  parameter int ATOMIC_VC = 1,
  parameter int DEBUG_EN  = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  ovc_credit_status_tracker_if.slave   bus
);
  localparam int PV = P * V;
  localparam int CW = $clog2(B + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(B);

  typedef enum logic [1:0] {
    ST_FREE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // A finished packet either waits for all credits (atomic) or frees at once.
  localparam state_e ST_AFTER_TAIL = (ATOMIC_VC != 0) ? ST_DRAIN : ST_FREE;

  state_e        state_q [PV];
  state_e        state_d [PV];
  logic [CW-1:0] cnt_q   [PV];
  logic [CW-1:0] cnt_d   [PV];
  logic [PV-1:0] err_q;
  logic [PV-1:0] err_d;
  logic [PV-1:0] err_ev_s;

  // State and counter registers with synchronous reset to FREE / full credits.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < PV; i++) begin
        state_q[i] <= ST_FREE;
        cnt_q[i]   <= CNT_FULL;
      end
      err_q <= '0;
    end else begin
      for (int i = 0; i < PV; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      err_q <= err_d;
    end
  end

  // Next-state, next-count and error-event decode for every OVC independently.
  always_comb begin
    err_ev_s = '0;
    err_d    = err_q;
    for (int i = 0; i < PV; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];

      // Send and credit together cancel; otherwise saturate without wrapping.
      case ({bus.flit_sent_all[i], bus.credit_in_all[i]})
        2'b10: begin
          if (cnt_q[i] == '0) begin
            err_ev_s[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] - CW'(1);
          end
        end
        2'b01: begin
          if (cnt_q[i] == CNT_FULL) begin
            err_ev_s[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end
        default: begin
          cnt_d[i] = cnt_q[i];
        end
      endcase

      case (state_q[i])
        ST_FREE: begin
          if (bus.ovc_alloc_all[i]) begin
            if (bus.flit_sent_all[i] && bus.tail_sent_all[i]) begin
              state_d[i] = ST_AFTER_TAIL;
            end else begin
              state_d[i] = ST_BUSY;
            end
          end else if (bus.flit_sent_all[i]) begin
            err_ev_s[i] = 1'b1;
          end else begin
            state_d[i] = ST_FREE;
          end
        end
        ST_BUSY: begin
          if (bus.ovc_alloc_all[i]) begin
            err_ev_s[i] = 1'b1;
          end else begin
            err_ev_s[i] = err_ev_s[i];
          end
          if (bus.flit_sent_all[i] && bus.tail_sent_all[i]) begin
            state_d[i] = ST_AFTER_TAIL;
          end else begin
            state_d[i] = ST_BUSY;
          end
        end
        ST_DRAIN: begin
          if (bus.ovc_alloc_all[i] || bus.flit_sent_all[i]) begin
            err_ev_s[i] = 1'b1;
          end else begin
            err_ev_s[i] = err_ev_s[i];
          end
          // Release on the edge where the count reaches full, same-cycle credit included.
          if (cnt_d[i] == CNT_FULL) begin
            state_d[i] = ST_FREE;
          end else begin
            state_d[i] = ST_DRAIN;
          end
        end
        default: begin
          state_d[i] = ST_FREE;
        end
      endcase

      if (DEBUG_EN != 0) begin
        err_d[i] = err_q[i] | err_ev_s[i];
      end else begin
        err_d[i] = 1'b0;
      end
    end
  end

  // Status outputs are pure decodes of the registered state and counts.
  always_comb begin
    bus.ovc_avalable_all = '0;
    bus.ovc_not_full_all = '0;
    bus.credit_cnt_all   = '0;
    for (int i = 0; i < PV; i++) begin
      bus.ovc_avalable_all[i]          = (state_q[i] == ST_FREE);
      bus.ovc_not_full_all[i]          = (cnt_q[i] != '0);
      bus.credit_cnt_all[i*CW +: CW]   = cnt_q[i];
    end
    bus.err_all = err_q;
  end

endmodule

// File: tb/tb_ovc_credit_status_tracker.sv
// Directed plus randomized bench: an atomic and a non-atomic instance share one
// stimulus stream and are checked every cycle against an arithmetic model.
module tb_ovc_credit_status_tracker;
  localparam int V  = 4;
  localparam int P  = 5;
  localparam int B  = 4;
  localparam int PV = P * V;
  localparam int CW = $clog2(B + 1);
  localparam int M_FREE  = 0;
  localparam int M_BUSY  = 1;
  localparam int M_DRAIN = 2;

  logic clk;
  logic rst;
  logic [PV-1:0] alloc_v, sent_v, tail_v, credit_v;

  int nassert = 0;
  int nfail   = 0;

  // index 0: ATOMIC_VC=0 instance, index 1: ATOMIC_VC=1 instance
  int mst  [2][PV];
  int mcnt [2][PV];
  bit merr [2][PV];

  ovc_credit_status_tracker_if #(.V(V), .P(P), .B(B)) if0 ();
  ovc_credit_status_tracker_if #(.V(V), .P(P), .B(B)) if1 ();

  assign if0.ovc_alloc_all = alloc_v;
  assign if0.flit_sent_all = sent_v;
  assign if0.tail_sent_all = tail_v;
  assign if0.credit_in_all = credit_v;
  assign if1.ovc_alloc_all = alloc_v;
  assign if1.flit_sent_all = sent_v;
  assign if1.tail_sent_all = tail_v;
  assign if1.credit_in_all = credit_v;

  ovc_credit_status_tracker #(.V(V), .P(P), .B(B), .ATOMIC_VC(0), .DEBUG_EN(1)) u0 (
    .clk(clk), .reset(rst), .bus(if0.slave));
  ovc_credit_status_tracker #(.V(V), .P(P), .B(B), .ATOMIC_VC(1), .DEBUG_EN(1)) u1 (
    .clk(clk), .reset(rst), .bus(if1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void model_step();
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < PV; i++) begin
        if (rst) begin
          mst[m][i] = M_FREE; mcnt[m][i] = B; merr[m][i] = 1'b0;
        end else begin
          bit a = alloc_v[i], s = sent_v[i], t = tail_v[i] & sent_v[i], c = credit_v[i];
          int n = mcnt[m][i] - int'(s) + int'(c);
          bit e = 1'b0;
          int after_tail = (m == 1) ? M_DRAIN : M_FREE;
          if (n < 0) begin n = 0; e = 1'b1; end
          if (n > B) begin n = B; e = 1'b1; end
          if (a && mst[m][i] != M_FREE) e = 1'b1;
          if (s && mst[m][i] == M_DRAIN) e = 1'b1;
          if (s && mst[m][i] == M_FREE && !a) e = 1'b1;
          if (mst[m][i] == M_FREE && a) mst[m][i] = (s && t) ? after_tail : M_BUSY;
          else if (mst[m][i] == M_BUSY && t) mst[m][i] = after_tail;
          else if (mst[m][i] == M_DRAIN && n == B) mst[m][i] = M_FREE;
          mcnt[m][i] = n;
          merr[m][i] = merr[m][i] | e;
        end
      end
    end
  endfunction

  function automatic logic [63:0] exp_vec(input int m, input int kind);
    logic [63:0] r = '0;
    for (int i = 0; i < PV; i++) begin
      case (kind)
        0: r[i] = (mst[m][i] == M_FREE);
        1: r[i] = (mcnt[m][i] != 0);
        2: r[i*CW +: CW] = CW'(mcnt[m][i]);
        default: r[i] = merr[m][i];
      endcase
    end
    return r;
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("u0_avail",   64'(if0.ovc_avalable_all), exp_vec(0, 0));
    chk("u0_notfull", 64'(if0.ovc_not_full_all), exp_vec(0, 1));
    chk("u0_cnt",     64'(if0.credit_cnt_all),   exp_vec(0, 2));
    chk("u0_err",     64'(if0.err_all),          exp_vec(0, 3));
    chk("u1_avail",   64'(if1.ovc_avalable_all), exp_vec(1, 0));
    chk("u1_notfull", 64'(if1.ovc_not_full_all), exp_vec(1, 1));
    chk("u1_cnt",     64'(if1.credit_cnt_all),   exp_vec(1, 2));
    chk("u1_err",     64'(if1.err_all),          exp_vec(1, 3));
  endtask

  task automatic drive(input int i, input bit a, input bit s, input bit t, input bit c);
    alloc_v = '0; sent_v = '0; tail_v = '0; credit_v = '0;
    alloc_v[i] = a; sent_v[i] = s; tail_v[i] = t; credit_v[i] = c;
    cycle();
  endtask

  function automatic logic [63:0] cnt_of(input logic [PV*CW-1:0] v, input int i);
    return 64'(v[i*CW +: CW]);
  endfunction

  initial begin
    logic [PV*CW-1:0] full_cnt;
    for (int i = 0; i < PV; i++) full_cnt[i*CW +: CW] = CW'(B);
    alloc_v = '0; sent_v = '0; tail_v = '0; credit_v = '0;
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    chk("rst_avail",   64'(if1.ovc_avalable_all), 64'hF_FFFF);
    chk("rst_notfull", 64'(if1.ovc_not_full_all), 64'hF_FFFF);
    chk("rst_cnt",     64'(if1.credit_cnt_all),   64'(full_cnt));
    chk("rst_err",     64'(if1.err_all),          64'h0);

    // OVC 7: alloc c0, sends c1..c3 with tail at c3, credits c5..c7
    drive(7, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(7, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(7, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(7, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("ovc7_cnt_after_tail", cnt_of(if1.credit_cnt_all, 7), 64'd1);
    drive(7, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ovc7_drain_unavail", 64'(if1.ovc_avalable_all[7]), 64'd0);
    chk("ovc7_nonatomic_free", 64'(if0.ovc_avalable_all[7]), 64'd1);
    drive(7, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(7, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovc7_still_drain", 64'(if1.ovc_avalable_all[7]), 64'd0);
    drive(7, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovc7_released", 64'(if1.ovc_avalable_all[7]), 64'd1);
    chk("ovc7_cnt_full", cnt_of(if1.credit_cnt_all, 7), 64'd4);

    // OVC 2: single-flit packet
    drive(2, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("ovc2_na_avail", 64'(if0.ovc_avalable_all[2]), 64'd1);
    chk("ovc2_na_cnt",   cnt_of(if0.credit_cnt_all, 2), 64'd3);
    chk("ovc2_na_err",   64'(if0.err_all[2]), 64'd0);
    chk("ovc2_at_drain", 64'(if1.ovc_avalable_all[2]), 64'd0);
    drive(2, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovc2_at_free",  64'(if1.ovc_avalable_all[2]), 64'd1);

    // OVC 0: credit exhaustion, underflow, cancelling send+credit
    drive(0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) drive(0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("ovc0_not_full", 64'(if1.ovc_not_full_all[0]), 64'd0);
    chk("ovc0_no_err_yet", 64'(if1.err_all[0]), 64'd0);
    drive(0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("ovc0_underflow_err", 64'(if1.err_all[0]), 64'd1);
    chk("ovc0_cnt_stays0", cnt_of(if1.credit_cnt_all, 0), 64'd0);
    drive(0, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(0, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("ovc0_send_credit", cnt_of(if1.credit_cnt_all, 0), 64'd2);

    // OVC 3: double allocation
    drive(3, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(3, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("ovc3_err", 64'(if1.err_all), 64'h9);
    chk("ovc3_busy", 64'(if1.ovc_avalable_all[3]), 64'd0);
    chk("ovc3_cnt", cnt_of(if1.credit_cnt_all, 3), 64'd4);

    // OVC 5: reset while draining
    drive(5, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(5, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(5, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(5, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("ovc5_drain", 64'(if1.ovc_avalable_all[5]), 64'd0);
    chk("ovc5_cnt1", cnt_of(if1.credit_cnt_all, 5), 64'd1);
    alloc_v = '1; sent_v = '1; tail_v = '1; credit_v = '0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("ovc5_rst_avail", 64'(if1.ovc_avalable_all), 64'hF_FFFF);
    chk("ovc5_rst_cnt", cnt_of(if1.credit_cnt_all, 5), 64'd4);
    chk("ovc5_rst_err", 64'(if1.err_all), 64'h0);

    // Randomized traffic with occasional resets
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < PV; i++) begin
        alloc_v[i]  = ($urandom_range(0, 5) == 0);
        sent_v[i]   = ($urandom_range(0, 2) == 0);
        tail_v[i]   = ($urandom_range(0, 2) == 0);
        credit_v[i] = ($urandom_range(0, 2) == 0);
      end
      rst = ($urandom_range(0, 59) == 0);
      cycle();
    end
    rst = 1'b0;
    alloc_v = '0; sent_v = '0; tail_v = '0; credit_v = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end
endmodule
